// File: rtl/vx_bcast_unit_pkg.sv
// Shared types and width helpers for the lane-broadcast execute unit.
package vx_bcast_unit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_e;

    localparam int DEF_NUM_THREADS = 4;
    localparam int DEF_NUM_LANES   = 4;
    localparam int DEF_XLEN        = 32;
    localparam int DEF_UUID_W      = 44;
    localparam int DEF_NW_W        = 2;
    localparam int DEF_NR_BITS     = 6;

    // Packet id width; a single-packet warp still carries a 1-bit pid.
    function automatic int calc_pid_w(input int nt, input int nl);
        return ((nt / nl) > 1) ? $clog2(nt / nl) : 1;
    endfunction

    // Thread (or lane) index width, never narrower than one bit.
    function automatic int calc_tid_w(input int nt);
        return (nt > 1) ? $clog2(nt) : 1;
    endfunction

endpackage

// File: rtl/vx_bcast_unit_if.sv
// Execute-side input and commit-side output buses of the broadcast unit.
interface vx_bcast_unit_if
    import vx_bcast_unit_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int XLEN      = DEF_XLEN,
    parameter int UUID_W    = DEF_UUID_W,
    parameter int NW_W      = DEF_NW_W,
    parameter int NR_BITS   = DEF_NR_BITS,
    parameter int PID_W     = 1,
    parameter int TID_W     = 2
);
    logic                            in_valid;
    logic                            in_ready;
    logic [UUID_W-1:0]               in_uuid;
    logic [NW_W-1:0]                 in_wid;
    logic [NUM_LANES-1:0]            in_tmask;
    logic [XLEN-1:0]                 in_PC;
    logic                            in_wb;
    logic [NR_BITS-1:0]              in_rd;
    logic [NUM_LANES-1:0][XLEN-1:0]  in_rs1_data;
    logic [TID_W-1:0]                in_src_tid;
    logic [PID_W-1:0]                in_pid;
    logic                            in_sop;
    logic                            in_eop;

    logic                            out_valid;
    logic                            out_ready;
    logic [UUID_W-1:0]               out_uuid;
    logic [NW_W-1:0]                 out_wid;
    logic [NUM_LANES-1:0]            out_tmask;
    logic [XLEN-1:0]                 out_PC;
    logic                            out_wb;
    logic [NR_BITS-1:0]              out_rd;
    logic [NUM_LANES-1:0][XLEN-1:0]  out_data;
    logic [PID_W-1:0]                out_pid;
    logic                            out_sop;
    logic                            out_eop;
    logic                            out_src_missing;

    modport master (
        output in_valid, in_uuid, in_wid, in_tmask, in_PC, in_wb, in_rd, in_rs1_data,
               in_src_tid, in_pid, in_sop, in_eop, out_ready,
        input  in_ready, out_valid, out_uuid, out_wid, out_tmask, out_PC, out_wb, out_rd,
               out_data, out_pid, out_sop, out_eop, out_src_missing
    );

    modport slave (
        input  in_valid, in_uuid, in_wid, in_tmask, in_PC, in_wb, in_rd, in_rs1_data,
               in_src_tid, in_pid, in_sop, in_eop, out_ready,
        output in_ready, out_valid, out_uuid, out_wid, out_tmask, out_PC, out_wb, out_rd,
               out_data, out_pid, out_sop, out_eop, out_src_missing
    );

endinterface

// File: rtl/vx_bcast_unit_fifo.sv
// Small synchronous FIFO holding packet headers of the warp being collected.
module vx_bcast_unit_fifo #(
    parameter int DATAW = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATAW-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign data_out = mem[rd_ptr];

    // Storage array: written on accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/vx_bcast_unit.sv
// Lane-broadcast unit: collects a warp's packets, captures the source
// thread's rs1 value, then replays every header with that value on all lanes.
module vx_bcast_unit
    import vx_bcast_unit_pkg::*;
#(
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int XLEN        = DEF_XLEN,
    parameter int UUID_W      = DEF_UUID_W,
    parameter int NW_W        = DEF_NW_W,
    parameter int NR_BITS     = DEF_NR_BITS
) (
    input  logic          clk,
    input  logic          reset,
    vx_bcast_unit_if.slave bus
);
    localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES;
    localparam int PID_W       = calc_pid_w(NUM_THREADS, NUM_LANES);
    localparam int TID_W       = calc_tid_w(NUM_THREADS);
    localparam int LANE_W      = calc_tid_w(NUM_LANES);

    typedef struct packed {
        logic [UUID_W-1:0]    uuid;
        logic [NW_W-1:0]      wid;
        logic [NUM_LANES-1:0] tmask;
        logic [XLEN-1:0]      pc;
        logic                 wb;
        logic [NR_BITS-1:0]   rd;
        logic [PID_W-1:0]     pid;
        logic                 sop;
        logic                 eop;
    } hdr_t;

    state_e           state;
    logic [TID_W-1:0] src_tid;
    logic [XLEN-1:0]  bcast;
    logic             src_found;
    logic             src_missing;

    hdr_t             in_hdr;
    hdr_t             head;
    logic             fifo_empty;
    logic             fifo_full;
    logic             in_fire;
    logic             out_fire;

    logic [TID_W-1:0]  cur_tid;
    logic [LANE_W-1:0] src_lane;
    logic              src_hit;
    logic              lane_on;
    logic              found_now;

    assign bus.in_ready  = (state != EMIT);
    assign in_fire       = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (state == EMIT) & ~fifo_empty;
    assign out_fire      = bus.out_valid & bus.out_ready;

    assign in_hdr = '{uuid:  bus.in_uuid,
                      wid:   bus.in_wid,
                      tmask: bus.in_tmask,
                      pc:    bus.in_PC,
                      wb:    bus.in_wb,
                      rd:    bus.in_rd,
                      pid:   bus.in_pid,
                      sop:   bus.in_sop,
                      eop:   bus.in_eop};

    vx_bcast_unit_fifo #(
        .DATAW ($bits(hdr_t)),
        .DEPTH (NUM_PACKETS)
    ) hdr_store (
        .clk      (clk),
        .reset    (reset),
        .push     (in_fire),
        .pop      (out_fire),
        .data_in  (in_hdr),
        .data_out (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // The sop packet carries the source tid itself; later packets use the latched copy.
    assign cur_tid   = bus.in_sop ? bus.in_src_tid : src_tid;
    assign src_hit   = (32'(bus.in_pid) == (32'(cur_tid) / NUM_LANES));
    assign src_lane  = LANE_W'(32'(cur_tid) % NUM_LANES);
    assign lane_on   = bus.in_tmask[src_lane];
    assign found_now = src_found & ~bus.in_sop;

    // Sequencing plus source-value capture; later assignments override earlier ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            src_tid     <= '0;
            bcast       <= '0;
            src_found   <= 1'b0;
            src_missing <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (in_fire) state <= bus.in_eop ? EMIT : COLLECT;
                COLLECT: if (in_fire && bus.in_eop) state <= EMIT;
                EMIT:    if (out_fire && head.eop) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (in_fire && bus.in_sop) begin
                src_tid     <= bus.in_src_tid;
                src_found   <= 1'b0;
                src_missing <= 1'b0;
            end

            if (in_fire && src_hit) begin
                bcast       <= lane_on ? bus.in_rs1_data[src_lane] : '0;
                src_missing <= ~lane_on;
                src_found   <= 1'b1;
            end else if (in_fire && bus.in_eop && !found_now) begin
                // Warp closed without the source packet ever showing up.
                bcast       <= '0;
                src_missing <= 1'b1;
            end
        end
    end

    assign bus.out_uuid        = head.uuid;
    assign bus.out_wid         = head.wid;
    assign bus.out_tmask       = head.tmask;
    assign bus.out_PC          = head.pc;
    assign bus.out_wb          = head.wb;
    assign bus.out_rd          = head.rd;
    assign bus.out_pid         = head.pid;
    assign bus.out_sop         = head.sop;
    assign bus.out_eop         = head.eop;
    assign bus.out_src_missing = src_missing;

    // Masked lanes still carry the broadcast value; tmask tells commit which count.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign bus.out_data[i] = bcast;
    end

    // Protocol checks: a warp must open with sop, and the header store never overflows.
    always_ff @(posedge clk) begin
        if (!reset && in_fire && state == IDLE)
            assert (bus.in_sop) else $error("vx_bcast_unit: packet without sop while idle");
        if (!reset && in_fire)
            assert (!fifo_full) else $error("vx_bcast_unit: header store overflow");
    end

endmodule

// File: tb/tb_vx_bcast_unit.sv
// Bench for vx_bcast_unit: a single-packet (4/4) and a two-packet (8/4)
// instance share one stimulus driver; sel picks which one is exercised.
module tb_vx_bcast_unit;
    import vx_bcast_unit_pkg::*;

    localparam int NL = 4, XL = 32, UW = 44, NWW = 2, NRB = 6;
    localparam int PW_A = calc_pid_w(4, NL);
    localparam int PW_B = calc_pid_w(8, NL);
    localparam int TW_A = calc_tid_w(4);
    localparam int TW_B = calc_tid_w(8);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vx_bcast_unit_if #(.NUM_LANES(NL), .XLEN(XL), .UUID_W(UW), .NW_W(NWW), .NR_BITS(NRB),
                       .PID_W(PW_A), .TID_W(TW_A)) bus_a ();
    vx_bcast_unit_if #(.NUM_LANES(NL), .XLEN(XL), .UUID_W(UW), .NW_W(NWW), .NR_BITS(NRB),
                       .PID_W(PW_B), .TID_W(TW_B)) bus_b ();

    vx_bcast_unit #(.NUM_THREADS(4), .NUM_LANES(NL), .XLEN(XL), .UUID_W(UW), .NW_W(NWW),
                    .NR_BITS(NRB)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    vx_bcast_unit #(.NUM_THREADS(8), .NUM_LANES(NL), .XLEN(XL), .UUID_W(UW), .NW_W(NWW),
                    .NR_BITS(NRB)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    // Shared drive signals
    bit                     sel = 1'b0;
    logic                   valid_s = 1'b0, ordy_s = 1'b0;
    logic [UW-1:0]          uuid_s = '0;
    logic [NWW-1:0]         wid_s = '0;
    logic [NL-1:0]          tmask_s = '0;
    logic [XL-1:0]          pc_s = '0;
    logic                   wb_s = 1'b0;
    logic [NRB-1:0]         rd_s = '0;
    logic [NL-1:0][XL-1:0]  rs1_s = '0;
    logic [2:0]             src_s = '0;
    logic [PW_B-1:0]        pid_s = '0;
    logic                   sop_s = 1'b0, eop_s = 1'b0;

    assign bus_a.in_valid = valid_s & ~sel;
    assign bus_b.in_valid = valid_s & sel;
    assign bus_a.in_uuid = uuid_s;      assign bus_b.in_uuid = uuid_s;
    assign bus_a.in_wid = wid_s;        assign bus_b.in_wid = wid_s;
    assign bus_a.in_tmask = tmask_s;    assign bus_b.in_tmask = tmask_s;
    assign bus_a.in_PC = pc_s;          assign bus_b.in_PC = pc_s;
    assign bus_a.in_wb = wb_s;          assign bus_b.in_wb = wb_s;
    assign bus_a.in_rd = rd_s;          assign bus_b.in_rd = rd_s;
    assign bus_a.in_rs1_data = rs1_s;   assign bus_b.in_rs1_data = rs1_s;
    assign bus_a.in_src_tid = src_s[TW_A-1:0];
    assign bus_b.in_src_tid = src_s[TW_B-1:0];
    assign bus_a.in_pid = pid_s[PW_A-1:0];
    assign bus_b.in_pid = pid_s;
    assign bus_a.in_sop = sop_s;        assign bus_b.in_sop = sop_s;
    assign bus_a.in_eop = eop_s;        assign bus_b.in_eop = eop_s;
    assign bus_a.out_ready = ordy_s;    assign bus_b.out_ready = ordy_s;

    // Observed outputs of the selected instance
    logic                   o_in_ready, o_valid, o_wb, o_sop, o_eop, o_miss;
    logic [UW-1:0]          o_uuid;
    logic [NWW-1:0]         o_wid;
    logic [NL-1:0]          o_tmask;
    logic [XL-1:0]          o_pc;
    logic [NRB-1:0]         o_rd;
    logic [NL-1:0][XL-1:0]  o_data;
    logic [PW_B-1:0]        o_pid;

    assign o_in_ready = sel ? bus_b.in_ready  : bus_a.in_ready;
    assign o_valid    = sel ? bus_b.out_valid : bus_a.out_valid;
    assign o_uuid     = sel ? bus_b.out_uuid  : bus_a.out_uuid;
    assign o_wid      = sel ? bus_b.out_wid   : bus_a.out_wid;
    assign o_tmask    = sel ? bus_b.out_tmask : bus_a.out_tmask;
    assign o_pc       = sel ? bus_b.out_PC    : bus_a.out_PC;
    assign o_wb       = sel ? bus_b.out_wb    : bus_a.out_wb;
    assign o_rd       = sel ? bus_b.out_rd    : bus_a.out_rd;
    assign o_data     = sel ? bus_b.out_data  : bus_a.out_data;
    assign o_pid      = sel ? bus_b.out_pid   : PW_B'(bus_a.out_pid);
    assign o_sop      = sel ? bus_b.out_sop   : bus_a.out_sop;
    assign o_eop      = sel ? bus_b.out_eop   : bus_a.out_eop;
    assign o_miss     = sel ? bus_b.out_src_missing : bus_a.out_src_missing;

    // Warp under test, as plain per-packet records
    logic [UW-1:0]          h_uuid  [2];
    logic [NWW-1:0]         h_wid   [2];
    logic [NL-1:0]          h_tmask [2];
    logic [XL-1:0]          h_pc    [2];
    logic                   h_wb    [2];
    logic [NRB-1:0]         h_rd    [2];
    logic [NL-1:0][XL-1:0]  h_rs1   [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pkt(input int k, input logic [NL-1:0][XL-1:0] v, input logic [NL-1:0] m);
        h_rs1[k]   = v;
        h_tmask[k] = m;
        h_uuid[k]  = UW'({$urandom, $urandom});
        h_wid[k]   = NWW'($urandom);
        h_pc[k]    = $urandom;
        h_wb[k]    = 1'($urandom);
        h_rd[k]    = NRB'($urandom);
    endtask

    task automatic rand_pkt(input int k);
        set_pkt(k, {$urandom, $urandom, $urandom, $urandom}, NL'($urandom));
    endtask

    // Present packet k for one cycle; src only meaningful on the sop packet.
    task automatic send_pkt(input int k, input int src, input bit last);
        valid_s = 1'b1;
        uuid_s  = h_uuid[k];  wid_s = h_wid[k];  tmask_s = h_tmask[k];
        pc_s    = h_pc[k];    wb_s  = h_wb[k];   rd_s    = h_rd[k];
        rs1_s   = h_rs1[k];
        pid_s   = PW_B'(k);
        sop_s   = (k == 0);
        eop_s   = last;
        src_s   = (k == 0) ? 3'(src) : 3'($urandom);
        @(posedge clk); #1;
        valid_s = 1'b0; sop_s = 1'b0; eop_s = 1'b0;
    endtask

    // Send a full warp, then drain and compare every commit to the model.
    // hold: initial cycles with out_ready low; rnd: random gaps and backpressure.
    task automatic run_warp(input int src, input int hold, input bit rnd);
        int npk, p, l, k, cyc, stall;
        logic [XL-1:0] exp_v;
        logic exp_m;
        bit fire;
        npk = sel ? 2 : 1;
        p = src / NL;
        l = src % NL;
        if (h_tmask[p][l]) begin exp_v = h_rs1[p][l]; exp_m = 1'b0; end
        else               begin exp_v = '0;          exp_m = 1'b1; end

        for (int i = 0; i < npk; i++) begin
            int g;
            g = rnd ? int'($urandom_range(0, 2)) : 0;
            repeat (g) begin
                chk("gap_in_ready", 64'(o_in_ready), 64'd1);
                chk("gap_out_valid", 64'(o_valid), 64'd0);
                @(posedge clk); #1;
            end
            chk("accept_ready", 64'(o_in_ready), 64'd1);
            send_pkt(i, src, i == npk - 1);
        end
        chk("eop_to_valid", 64'(o_valid), 64'd1);

        k = 0; cyc = 0; stall = hold;
        while (k < npk && cyc < 60) begin
            if (stall > 0) begin ordy_s = 1'b0; stall--; end
            else if (rnd)  ordy_s = ($urandom_range(0, 3) != 0);
            else           ordy_s = 1'b1;
            chk("emit_in_ready", 64'(o_in_ready), 64'd0);
            chk("emit_valid", 64'(o_valid), 64'd1);
            if (o_valid === 1'b1) begin
                chk("out_uuid", 64'(o_uuid), 64'(h_uuid[k]));
                chk("out_wid", 64'(o_wid), 64'(h_wid[k]));
                chk("out_tmask", 64'(o_tmask), 64'(h_tmask[k]));
                chk("out_pc", 64'(o_pc), 64'(h_pc[k]));
                chk("out_wb", 64'(o_wb), 64'(h_wb[k]));
                chk("out_rd", 64'(o_rd), 64'(h_rd[k]));
                chk("out_pid", 64'(o_pid), 64'(k));
                chk("out_sop", 64'(o_sop), 64'(k == 0));
                chk("out_eop", 64'(o_eop), 64'(k == npk - 1));
                chk("out_missing", 64'(o_miss), 64'(exp_m));
                for (int i = 0; i < NL; i++) chk("out_data", 64'(o_data[i]), 64'(exp_v));
            end
            fire = (o_valid === 1'b1) && ordy_s;
            @(posedge clk); #1;
            cyc++;
            if (fire) k++;
        end
        ordy_s = 1'b0;
        chk("drain_done", 64'(k), 64'(npk));
        if (!rnd && hold == 0) chk("drain_cycles", 64'(cyc), 64'(npk));
        chk("idle_valid", 64'(o_valid), 64'd0);
        chk("idle_ready", 64'(o_in_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values on both instances
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_in_ready", 64'(bus_a.in_ready), 64'd1);
        chk("rst_a_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("rst_a_missing", 64'(bus_a.out_src_missing), 64'd0);
        chk("rst_b_in_ready", 64'(bus_b.in_ready), 64'd1);
        chk("rst_b_out_valid", 64'(bus_b.out_valid), 64'd0);
        chk("rst_b_missing", 64'(bus_b.out_src_missing), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single packet warp: lane 2 holds 30
        sel = 1'b0;
        set_pkt(0, {32'd40, 32'd30, 32'd20, 32'd10}, 4'b1111);
        run_warp(2, 0, 1'b0);

        // Two packets, source thread 6 is pkt1 lane2 = 7
        sel = 1'b1;
        set_pkt(0, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111);
        set_pkt(1, {32'd8, 32'd7, 32'd6, 32'd5}, 4'b1111);
        run_warp(6, 0, 1'b0);

        // Source lane masked off -> zero and missing flag
        set_pkt(0, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111);
        set_pkt(1, {32'd8, 32'd7, 32'd6, 32'd5}, 4'b1011);
        run_warp(6, 0, 1'b0);

        // Commit stalled for 5 cycles at the start of emission
        rand_pkt(0); rand_pkt(1);
        run_warp(5, 5, 1'b0);

        // Reset in the middle of collection drops the partial warp
        rand_pkt(0); rand_pkt(1);
        send_pkt(0, 3, 1'b0);
        chk("collect_ready", 64'(o_in_ready), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin
            chk("post_reset_valid", 64'(o_valid), 64'd0);
            chk("post_reset_ready", 64'(o_in_ready), 64'd1);
            @(posedge clk); #1;
        end
        set_pkt(0, {32'd1, 32'd2, 32'd3, 32'd4}, 4'b1111);
        rand_pkt(1);
        run_warp(1, 0, 1'b0);

        // Back-to-back warps with no idle gap between them
        rand_pkt(0); rand_pkt(1);
        run_warp(0, 0, 1'b0);
        rand_pkt(0); rand_pkt(1);
        run_warp(7, 0, 1'b0);

        // Randomized warps on both instances
        for (int n = 0; n < 60; n++) begin
            sel = 1'($urandom);
            rand_pkt(0); rand_pkt(1);
            run_warp(sel ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
